// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the two-requester I2C command arbiter.
package i2c_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int NREQ   = 2;

  localparam logic [15:0] TIMEOUT_DEF = 16'd65535;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GRANT = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT,
    S_EXEC  = ST_EXEC,
    S_WAIT  = ST_WAIT,
    S_RESP  = ST_RESP
  } arb_state_e;

endpackage

// File: rtl/i2c_req_arbiter_rr_arb2.sv
// Two-way round-robin picker; ptr holds the last granted index and therefore
// the owner of the transaction in flight.
module rr_arb2
  import i2c_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid,
  input  logic            update,
  output logic            grant,
  output logic            ptr
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = 1'b0;
    if (valid == 2'b11) begin
      grant = ~ptr_q;
    end else if (valid[1]) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update) begin
      ptr_d = grant;
    end
  end

  // Reset to "requester 1 went last" so requester 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C driver command port between two requesters: round-robin grant,
// single exec pulse, bounded wait for done, then a completion pulse to the owner.
//
// state   | meaning
// IDLE    | no transaction; sample req_valid
// GRANT   | req_ready to winner, winner fields already on i2c_*
// EXEC    | one-cycle i2c_exec to the driver
// WAIT    | count cycles until i2c_done or timeout
// RESP    | rsp_valid to owner, account error, back to IDLE
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_rh_wl,
  input  logic [NREQ-1:0]        req_bit_ctrl,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [7:0]             err_cnt,
  output logic                   i2c_exec,
  output logic                   i2c_rh_wl,
  output logic                   i2c_bit_ctrl,
  output logic [ADDR_W-1:0]      i2c_addr,
  output logic [DATA_W-1:0]      i2c_data_w,
  input  logic                   i2c_done,
  input  logic                   i2c_ack,
  input  logic [DATA_W-1:0]      i2c_data_r
);

  arb_state_e        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              i2c_exec_q, i2c_exec_d;
  logic              i2c_rh_wl_q, i2c_rh_wl_d;
  logic              i2c_bit_ctrl_q, i2c_bit_ctrl_d;
  logic [ADDR_W-1:0] i2c_addr_q, i2c_addr_d;
  logic [DATA_W-1:0] i2c_data_w_q, i2c_data_w_d;

  logic              rr_grant;
  logic              rr_ptr;
  logic              rr_update;
  logic [NREQ-1:0]   owner_oh;

  rr_arb2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (req_valid),
    .update (rr_update),
    .grant  (rr_grant),
    .ptr    (rr_ptr)
  );

  // The pointer only moves on a grant, so it names the owner until the next one.
  assign owner_oh = rr_ptr ? 2'b10 : 2'b01;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_ready_d    = '0;
    rsp_valid_d    = '0;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    err_cnt_d      = err_cnt_q;
    i2c_exec_d     = 1'b0;
    i2c_rh_wl_d    = i2c_rh_wl_q;
    i2c_bit_ctrl_d = i2c_bit_ctrl_q;
    i2c_addr_d     = i2c_addr_q;
    i2c_data_w_d   = i2c_data_w_q;
    rr_update      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          state_d        = S_GRANT;
          rr_update      = 1'b1;
          req_ready_d    = rr_grant ? 2'b10 : 2'b01;
          i2c_rh_wl_d    = req_rh_wl[rr_grant];
          i2c_bit_ctrl_d = req_bit_ctrl[rr_grant];
          i2c_addr_d     = rr_grant ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          i2c_data_w_d   = rr_grant ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        end
      end
      S_GRANT: begin
        state_d    = S_EXEC;
        i2c_exec_d = 1'b1;
      end
      S_EXEC: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // done wins over a timeout landing on the same cycle
        if (i2c_done) begin
          state_d     = S_RESP;
          rsp_valid_d = owner_oh;
          rsp_err_d   = i2c_ack;
          rsp_rdata_d = i2c_rh_wl_q ? i2c_data_r : 8'h00;
        end else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
          state_d     = S_RESP;
          rsp_valid_d = owner_oh;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (rsp_err_q && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      req_ready_q    <= '0;
      rsp_valid_q    <= '0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      busy_q         <= 1'b0;
      err_cnt_q      <= '0;
      i2c_exec_q     <= 1'b0;
      i2c_rh_wl_q    <= 1'b0;
      i2c_bit_ctrl_q <= 1'b0;
      i2c_addr_q     <= '0;
      i2c_data_w_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      busy_q         <= busy_d;
      err_cnt_q      <= err_cnt_d;
      i2c_exec_q     <= i2c_exec_d;
      i2c_rh_wl_q    <= i2c_rh_wl_d;
      i2c_bit_ctrl_q <= i2c_bit_ctrl_d;
      i2c_addr_q     <= i2c_addr_d;
      i2c_data_w_q   <= i2c_data_w_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = busy_q;
  assign err_cnt      = err_cnt_q;
  assign i2c_exec     = i2c_exec_q;
  assign i2c_rh_wl    = i2c_rh_wl_q;
  assign i2c_bit_ctrl = i2c_bit_ctrl_q;
  assign i2c_addr     = i2c_addr_q;
  assign i2c_data_w   = i2c_data_w_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: requester and driver agents, a transaction-timeline
// reference, and directed scenarios followed by a randomized run.
module tb_i2c_req_arbiter;

  localparam int TO = 8;

  typedef struct packed {
    logic        rw;
    logic        bc;
    logic [15:0] addr;
    logic [7:0]  wd;
  } rq_t;

  typedef struct packed {
    int unsigned k;
    logic        ack;
    logic [7:0]  d;
  } dr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_rh_wl = '0;
  logic [1:0]  req_bit_ctrl = '0;
  logic [31:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        i2c_done = 1'b0;
  logic        i2c_ack = 1'b0;
  logic [7:0]  i2c_data_r = '0;
  logic [1:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_rdata, err_cnt, i2c_data_w;
  logic        rsp_err, busy, i2c_exec, i2c_rh_wl, i2c_bit_ctrl;
  logic [15:0] i2c_addr;

  always #5 clk = ~clk;

  i2c_req_arbiter #(.TIMEOUT_CYC(16'd8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rh_wl    (req_rh_wl),
    .req_bit_ctrl (req_bit_ctrl),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .err_cnt      (err_cnt),
    .i2c_exec     (i2c_exec),
    .i2c_rh_wl    (i2c_rh_wl),
    .i2c_bit_ctrl (i2c_bit_ctrl),
    .i2c_addr     (i2c_addr),
    .i2c_data_w   (i2c_data_w),
    .i2c_done     (i2c_done),
    .i2c_ack      (i2c_ack),
    .i2c_data_r   (i2c_data_r)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rq_t mk_rq(input logic rw, input logic bc, input logic [15:0] a,
                                input logic [7:0] w);
    rq_t t;
    t.rw = rw; t.bc = bc; t.addr = a; t.wd = w;
    return t;
  endfunction

  function automatic dr_t mk_dr(input int unsigned k, input logic ack, input logic [7:0] d);
    dr_t t;
    t.k = k; t.ack = ack; t.d = d;
    return t;
  endfunction

  // ---------------- reference: one transaction as a timeline of cycle numbers
  int          cyc = 0;
  bit          m_act = 1'b0, m_last = 1'b1, m_win = 1'b0, m_err = 1'b0;
  int          m_g = 0, m_w0 = 0, m_r = -1;
  logic [7:0]  m_rdata = '0, m_errcnt = '0;
  logic        e_rw = 1'b0, e_bc = 1'b0, e_exec = 1'b0, e_busy = 1'b0, e_rerr = 1'b0;
  logic [15:0] e_addr = '0;
  logic [7:0]  e_wd = '0, e_rdata = '0;
  logic [1:0]  e_ready = '0, e_rsp_valid = '0;

  task automatic model_reset();
    m_act = 1'b0; m_last = 1'b1; m_errcnt = '0; m_r = -1;
    e_rw = 1'b0; e_bc = 1'b0; e_addr = '0; e_wd = '0; e_exec = 1'b0; e_busy = 1'b0;
    e_ready = '0; e_rsp_valid = '0; e_rdata = '0; e_rerr = 1'b0;
  endtask

  task automatic model_step();
    int n;
    cyc++;
    n = cyc;
    if (m_act && m_r >= 0 && n - 1 == m_r) begin
      m_act = 1'b0;
      if (m_err && m_errcnt != 8'hFF) m_errcnt++;
    end else if (m_act && m_r < 0 && n - 1 >= m_w0) begin
      if (i2c_done) begin
        m_r = n; m_err = i2c_ack; m_rdata = e_rw ? i2c_data_r : 8'h00;
      end else if (n - 1 - m_w0 == TO - 1) begin
        m_r = n; m_err = 1'b1; m_rdata = 8'h00;
      end
    end else if (!m_act && req_valid != 2'b00) begin
      m_win  = (req_valid == 2'b11) ? ~m_last : req_valid[1];
      m_last = m_win;
      m_act  = 1'b1; m_g = n; m_w0 = n + 2; m_r = -1;
      e_rw   = req_rh_wl[m_win];
      e_bc   = req_bit_ctrl[m_win];
      e_addr = m_win ? req_addr[31:16] : req_addr[15:0];
      e_wd   = m_win ? req_wdata[15:8] : req_wdata[7:0];
    end
    e_ready = (m_act && n == m_g) ? (m_win ? 2'b10 : 2'b01) : 2'b00;
    e_exec  = m_act && (n == m_g + 1);
    e_busy  = m_act;
    if (m_act && n == m_r) begin
      e_rsp_valid = m_win ? 2'b10 : 2'b01;
      e_rdata = m_rdata;
      e_rerr  = m_err;
    end else begin
      e_rsp_valid = 2'b00;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  // ---------------- monitor + per-cycle compare
  logic [1:0]  rdy_seen = '0;
  bit          exec_seen = 1'b0, rsp_seen = 1'b0;
  int          exec_cnt = 0, rsp_cnt = 0, exec_cyc = 0, rsp_cyc = 0;
  logic [1:0]  l_rv = '0;
  logic [7:0]  l_rdata = '0;
  logic        l_err = 1'b0;
  int          glog[$];

  initial forever begin
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("i2c_exec", 32'(i2c_exec), 32'(e_exec));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
    chk("rsp_err", 32'(rsp_err), 32'(e_rerr));
    chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
    chk("i2c_fields", {15'd0, i2c_rh_wl, i2c_bit_ctrl, i2c_addr[14:0]}, {15'd0, e_rw, e_bc, e_addr[14:0]});
    chk("i2c_hi", {16'd0, i2c_addr[15], 7'd0, i2c_data_w}, {16'd0, e_addr[15], 7'd0, e_wd});
    if (req_ready != 2'b00) begin
      rdy_seen = req_ready;
      glog.push_back(int'(req_ready[1]));
    end
    if (i2c_exec) begin exec_seen = 1'b1; exec_cnt++; exec_cyc = cyc; end
    if (rsp_valid != 2'b00) begin
      rsp_seen = 1'b1; rsp_cnt++; rsp_cyc = cyc;
      l_rv = rsp_valid; l_rdata = rsp_rdata; l_err = rsp_err;
    end
  end

  // ---------------- requester and driver agents
  rq_t         rq0[$], rq1[$];
  dr_t         dq[$];
  bit          rand_mode = 1'b0;
  bit          armed = 1'b0, fired = 1'b0;
  dr_t         cur;
  int unsigned dcnt = 0;

  function automatic rq_t rnd_rq();
    return mk_rq(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom));
  endfunction

  initial forever begin
    rq_t t;
    @(posedge clk);
    #2;
    if (!rst_n) begin
      req_valid = '0; i2c_done = 1'b0; armed = 1'b0; fired = 1'b0;
      exec_seen = 1'b0; rsp_seen = 1'b0; rdy_seen = '0;
    end else begin
      if (rand_mode && rq0.size() < 2 && $urandom_range(0, 3) == 0) rq0.push_back(rnd_rq());
      if (rand_mode && rq1.size() < 2 && $urandom_range(0, 3) == 0) rq1.push_back(rnd_rq());
      if (rdy_seen[0] && rq0.size() > 0) t = rq0.pop_front();
      if (rdy_seen[1] && rq1.size() > 0) t = rq1.pop_front();
      rdy_seen = '0;
      t = (rq0.size() > 0) ? rq0[0] : rnd_rq();
      req_valid[0] = (rq0.size() > 0);
      req_rh_wl[0] = t.rw; req_bit_ctrl[0] = t.bc; req_addr[15:0] = t.addr; req_wdata[7:0] = t.wd;
      t = (rq1.size() > 0) ? rq1[0] : rnd_rq();
      req_valid[1] = (rq1.size() > 0);
      req_rh_wl[1] = t.rw; req_bit_ctrl[1] = t.bc; req_addr[31:16] = t.addr; req_wdata[15:8] = t.wd;

      if (rsp_seen) armed = 1'b0;
      rsp_seen = 1'b0;
      i2c_done = 1'b0;
      i2c_ack = 1'($urandom);
      i2c_data_r = 8'($urandom);
      if (exec_seen) begin
        exec_seen = 1'b0; armed = 1'b1; fired = 1'b0; dcnt = 0;
        if (dq.size() > 0) cur = dq.pop_front();
        else if (rand_mode)
          cur = mk_dr(($urandom_range(0, 9) < 3) ? 99 : $urandom_range(0, 7),
                      1'($urandom), 8'($urandom));
        else cur = mk_dr(0, 1'b0, 8'h00);
      end
      if (armed) begin
        if (!fired && dcnt == cur.k) begin
          i2c_done = 1'b1; i2c_ack = cur.ack; i2c_data_r = cur.d; fired = 1'b1;
        end
        dcnt++;
      end else if (rand_mode && $urandom_range(0, 7) == 0) begin
        i2c_done = 1'b1;
      end
    end
  end

  // ---------------- directed scenarios, then random
  task automatic wait_rsp(input string nm, input int target, input int budget);
    int n;
    n = 0;
    while (rsp_cnt < target && n < budget) begin
      @(negedge clk); #1; n++;
    end
    chk(nm, 32'(rsp_cnt), 32'(target));
  endtask

  task automatic pulse_reset(input int ncyc);
    @(posedge clk); #1;
    rst_n = 1'b0;
    rq0.delete(); rq1.delete(); dq.delete();
    @(negedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", {rsp_valid, req_ready, i2c_exec, rsp_err, i2c_rh_wl, i2c_bit_ctrl},
        32'd0);
    chk("rst_data", {err_cnt, rsp_rdata, i2c_addr}, 32'd0);
    chk("rst_wdata", 32'(i2c_data_w), 32'd0);
    repeat (ncyc) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int base, e0, n;
    pulse_reset(2);

    // simultaneous requests held over several transactions
    glog.delete();
    base = rsp_cnt;
    rq0.push_back(mk_rq(1'b0, 1'b0, 16'h0A00, 8'h01));
    rq0.push_back(mk_rq(1'b0, 1'b0, 16'h0A01, 8'h02));
    rq1.push_back(mk_rq(1'b0, 1'b0, 16'h0B00, 8'h03));
    rq1.push_back(mk_rq(1'b0, 1'b0, 16'h0B01, 8'h04));
    repeat (4) dq.push_back(mk_dr(1, 1'b0, 8'h00));
    wait_rsp("sim_rsp", base + 4, 200);
    chk("sim_ngrant", 32'(glog.size()), 32'd4);
    if (glog.size() >= 3) begin
      chk("sim_g0", 32'(glog[0]), 32'd0);
      chk("sim_g1", 32'(glog[1]), 32'd1);
      chk("sim_g2", 32'(glog[2]), 32'd0);
    end

    // single write from requester 0
    e0 = exec_cnt; base = rsp_cnt;
    rq0.push_back(mk_rq(1'b0, 1'b0, 16'h0010, 8'hA5));
    dq.push_back(mk_dr(2, 1'b0, 8'hFF));
    wait_rsp("wr_rsp", base + 1, 100);
    chk("wr_nexec", 32'(exec_cnt - e0), 32'd1);
    chk("wr_rv", 32'(l_rv), 32'h1);
    chk("wr_err", 32'(l_err), 32'h0);
    chk("wr_rdata", 32'(l_rdata), 32'h00);
    chk("wr_addr", 32'(i2c_addr), 32'h0010);
    chk("wr_wdata", 32'(i2c_data_w), 32'hA5);

    // read from requester 1
    base = rsp_cnt;
    rq1.push_back(mk_rq(1'b1, 1'b1, 16'h0123, 8'h00));
    dq.push_back(mk_dr(3, 1'b0, 8'h5C));
    wait_rsp("rd_rsp", base + 1, 100);
    chk("rd_rv", 32'(l_rv), 32'h2);
    chk("rd_rdata", 32'(l_rdata), 32'h5C);
    chk("rd_bc", 32'(i2c_bit_ctrl), 32'h1);

    // NACK
    base = rsp_cnt;
    rq0.push_back(mk_rq(1'b0, 1'b0, 16'h0042, 8'h11));
    dq.push_back(mk_dr(0, 1'b1, 8'h00));
    wait_rsp("nack_rsp", base + 1, 100);
    chk("nack_err", 32'(l_err), 32'h1);
    @(negedge clk); #1;
    chk("nack_cnt", 32'(err_cnt), 32'd1);

    // timeout: no done at all
    base = rsp_cnt;
    rq0.push_back(mk_rq(1'b0, 1'b0, 16'h0043, 8'h22));
    dq.push_back(mk_dr(99, 1'b0, 8'h00));
    wait_rsp("to_rsp", base + 1, 100);
    chk("to_lat", 32'(rsp_cyc - exec_cyc), 32'd9);
    chk("to_err", 32'(l_err), 32'h1);
    chk("to_rdata", 32'(l_rdata), 32'h00);
    @(negedge clk); #1;
    chk("to_cnt", 32'(err_cnt), 32'd2);

    // done on the timeout cycle counts as a normal completion
    base = rsp_cnt;
    rq1.push_back(mk_rq(1'b1, 1'b0, 16'h0044, 8'h00));
    dq.push_back(mk_dr(7, 1'b0, 8'h3C));
    wait_rsp("edge_rsp", base + 1, 100);
    chk("edge_lat", 32'(rsp_cyc - exec_cyc), 32'd9);
    chk("edge_err", 32'(l_err), 32'h0);
    chk("edge_rdata", 32'(l_rdata), 32'h3C);
    @(negedge clk); #1;
    chk("edge_cnt", 32'(err_cnt), 32'd2);

    // reset while waiting on the driver
    base = rsp_cnt; e0 = exec_cnt;
    rq0.push_back(mk_rq(1'b0, 1'b0, 16'h0055, 8'h33));
    dq.push_back(mk_dr(99, 1'b0, 8'h00));
    n = 0;
    while (exec_cnt == e0 && n < 50) begin @(negedge clk); #1; n++; end
    chk("rw_exec", 32'(exec_cnt - e0), 32'd1);
    repeat (3) @(negedge clk);
    pulse_reset(2);
    repeat (12) @(negedge clk);
    #1;
    chk("rw_norsp", 32'(rsp_cnt), 32'(base));
    glog.delete();
    rq0.push_back(mk_rq(1'b0, 1'b0, 16'h0066, 8'h44));
    rq1.push_back(mk_rq(1'b0, 1'b0, 16'h0077, 8'h55));
    dq.push_back(mk_dr(0, 1'b0, 8'h00));
    dq.push_back(mk_dr(0, 1'b0, 8'h00));
    wait_rsp("rw_rsp", base + 2, 100);
    if (glog.size() > 0) chk("rw_tie", 32'(glog[0]), 32'd0);
    else chk("rw_tie_seen", 32'(glog.size()), 32'd1);

    // randomized traffic
    rand_mode = 1'b1;
    repeat (8000) @(negedge clk);
    rand_mode = 1'b0;
    n = 0;
    while ((rq0.size() > 0 || rq1.size() > 0 || busy) && n < 500) begin
      @(negedge clk); #1; n++;
    end
    chk("drain", 32'(n < 500), 32'd1);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
